fir_out_quantizer: RTL and testbench
====================================

# fir_out_quantizer

Output conditioning stage placed directly downstream of the L2/L3 parallel FIR filters, in the `clk_serial` domain. It takes the filter's 24-bit serial output, rounds and saturates it to a 16-bit sample, and buffers the result in a small FIFO behind a valid/ready handshake. It also maintains saturation and drop statistics. The FIR cannot stall, so this block never back-pressures its input; samples that find the FIFO full are dropped and counted.

## Interface
- `SHIFT`, 8: right-shift applied before quantisation; legal range 1..8.
- `DEPTH`, 4: FIFO depth in entries; power of two, at least 2.
- `clk` in 1: single clock, driven by the FIR's `clk_serial`.
- `reset` in 1: asynchronous, active-low; asserting it clears all state immediately.
- `en` in 1: qualifies `data_in` this cycle; same enable the FIR uses.
- `data_in` in 24: signed two's-complement FIR output (`data_out` of the FIR).
- `clear` in 1: synchronous clear of `sat_count`, `drop_count` and `overflow` only.
- `out_data` out 16: signed sample at FIFO head.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts the head sample this cycle.
- `level` out clog2(DEPTH)+1: current FIFO occupancy.
- `sat_count` out 16: number of saturated samples; holds at 0xFFFF.
- `drop_count` out 16: number of samples dropped on a full FIFO; holds at 0xFFFF.
- `overflow` out 1: sticky flag, set on any saturation or drop.

## Operation
- **Quantiser (stage Q)**
  - On an `en` cycle, compute `t = data_in + 2^(SHIFT-1)` at 25-bit signed width, so the addition cannot wrap.
  - Compute `r = t >>> SHIFT` (arithmetic shift). This is round-half-up, i.e. toward +infinity on ties.
  - If `r > 32767`, the result is 32767. If `r < -32768`, the result is -32768. In either case the sample is marked saturated.
  - Register the result into `q_data` and set `q_valid` = 1.
  - On a non-`en` cycle, `q_valid` = 0.
- **FIFO**
  - Circular buffer with read and write pointers and an occupancy count.
  - Push = `q_valid` and (`level` < DEPTH, or a pop occurs this cycle).
  - Pop = `out_valid` and `out_ready`.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full or when it is empty. In the empty case the pushed word becomes visible on the next cycle; there is no combinational bypass.
  - Pointers wrap modulo DEPTH.
  - `out_data` is the entry at the read pointer. When the FIFO is empty, `out_data` holds its last value and has no meaning.
- **Drop**
  - A drop occurs when `q_valid` = 1, `level` = DEPTH and there is no pop.
  - The sample is discarded, `drop_count` increments (saturating) and `overflow` is set.
- **Statistics**
  - Each saturated sample in stage Q increments `sat_count` (saturating) and sets `overflow`. This happens whether or not the sample is later dropped.
  - `clear` takes effect on the next edge. If `clear` coincides with an increment event, `clear` wins and the counter becomes 0.
- **Handshake rule**: while `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_valid` must remain stable.

## Timing
- **Reset values**: `out_data` = 0, `out_valid` = 0, `level` = 0, `sat_count` = 0, `drop_count` = 0, `overflow` = 0. Internally, `q_valid` = 0 and the pointers = 0.
- **Latency**: a sample presented with `en` at edge N is in `q_data` after edge N, is written to the FIFO at edge N+1, and `out_valid` rises after edge N+1 if the FIFO was empty. That is 2 cycles from input to output.
- **Throughput**: one sample per cycle, sustained while `out_ready` = 1.
- **Reset mid-operation**: asserting `reset` at any point empties the FIFO and the Q stage asynchronously, and all outputs go to their reset values without waiting for a clock. The first `en` sample after deassertion follows the normal 2-cycle latency.
- **`en` gaps**: insert bubbles only. The FIFO continues to drain normally.

## Test plan
- **Rounding**, SHIFT=8: drive `data_in` 0x000180, 0xFFFE80, 0x00007F, 0x000080 on consecutive `en` cycles with `out_ready` = 1.
  - Required `out_data`: 2, -1, 0, 1, with the first value appearing 2 cycles after the first input.
  - `sat_count` stays 0.
- **Saturation**: drive `data_in` 0x7FFFFF, then 0x7FFF80, then 0x800000.
  - Required `out_data`: 32767, 32767, -32768.
  - `sat_count` = 2 and `overflow` = 1; the input 0x800000 does not saturate.
- **Full FIFO drop**, DEPTH=4, `out_ready` = 0: apply 6 consecutive `en` samples 1..6 (pre-shifted, i.e. value << 8).
  - Required: `level` = 4, `drop_count` = 2, and samples 1..4 are delivered in order once `out_ready` = 1.
- **Simultaneous push/pop at full**: fill the FIFO to 4, then hold `en` = 1 and `out_ready` = 1 for 10 cycles.
  - Required: `level` stays 4, `drop_count` does not change, and the output sequence has no gaps or duplicates.
- **Clear vs. event**: assert `clear` in the same cycle that a saturating sample occupies stage Q.
  - Required: `sat_count` = 0 and `overflow` = 0 after the edge.
- **Asynchronous reset mid-stream**: pull `reset` low between edges while `level` = 3.
  - Required: `out_valid` = 0, `level` = 0 and all counters = 0 immediately.
  - After release, the first sample arrives exactly 2 cycles after its `en`.

Source files
------------

// File: rtl/fir_out_quantizer.sv
// fir_out_quantizer: rounds/saturates the 24-bit FIR output to 16 bits,
// buffers samples in a small FIFO behind valid/ready, keeps sat/drop stats.
//
// Ports:
//   clk        single clock (the FIR's serial clock)
//   reset      asynchronous, active-low; clears all state
//   en         qualifies data_in this cycle
//   data_in    signed 24-bit FIR output
//   clear      synchronous clear of sat_count, drop_count, overflow
//   out_data   signed 16-bit sample at FIFO head
//   out_valid  FIFO non-empty
//   out_ready  consumer takes the head sample this cycle
//   level      FIFO occupancy
//   sat_count  saturated-sample count, sticks at 0xFFFF
//   drop_count dropped-sample count, sticks at 0xFFFF
//   overflow   sticky: any saturation or drop since clear/reset

module fir_out_quantizer #(
  parameter int SHIFT = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [23:0]              data_in,
  input  logic                     clear,
  output logic [15:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              sat_count,
  output logic [15:0]              drop_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic signed [24:0] HALF =
    25'sd1 <<< (SHIFT - 1);
  localparam logic signed [24:0] MAXV = 25'sd32767;
  localparam logic signed [24:0] MINV = -25'sd32768;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  // ---------------- quantiser ----------------
  logic signed [24:0] t;
  logic signed [24:0] r;
  logic               sat_hi;
  logic               sat_lo;
  logic [15:0]        q_calc;

  // 25-bit sum: adding the half-LSB can never wrap
  always_comb begin
    t      = $signed({data_in[23], data_in}) + HALF;
    r      = t >>> SHIFT;
    sat_hi = r > MAXV;
    sat_lo = r < MINV;
    q_calc = r[15:0];
    if (sat_hi) q_calc = 16'h7fff;
    if (sat_lo) q_calc = 16'h8000;
  end

  logic        q_valid;
  logic [15:0] q_data;
  logic        q_sat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_sat   <= 1'b0;
    end else begin
      q_valid <= en;
      if (en) begin
        q_data <= q_calc;
        q_sat  <= sat_hi | sat_lo;
      end
    end
  end

  // ---------------- FIFO ----------------
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_nxt;
  logic [AW-1:0] wr_nxt;
  logic [LW-1:0] cnt;
  logic [LW-1:0] cnt_nxt;
  logic [15:0]   head_nxt;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign full      = cnt == FULL;
  assign out_valid = cnt != '0;
  assign level     = cnt;
  assign pop       = out_valid & out_ready;
  assign push      = q_valid & (~full | pop);
  assign drop      = q_valid & full & ~pop;

  always_comb begin
    rd_nxt = pop  ? rd_ptr + AW'(1) : rd_ptr;
    wr_nxt = push ? wr_ptr + AW'(1) : wr_ptr;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + LW'(1);
      2'b01:   cnt_nxt = cnt - LW'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  // out_data is registered: look ahead to the entry that will be at
  // the head after this edge. If that slot is being written now (the
  // only entry), take the incoming word; empty keeps the last value.
  always_comb begin
    head_nxt = out_data;
    if (cnt_nxt != '0) begin
      if (push && (wr_ptr == rd_nxt))
        head_nxt = q_data;
      else
        head_nxt = mem[rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= q_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      rd_ptr   <= rd_nxt;
      wr_ptr   <= wr_nxt;
      cnt      <= cnt_nxt;
      out_data <= head_nxt;
    end
  end

  // ---------------- statistics ----------------
  logic sat_ev;

  assign sat_ev = q_valid & q_sat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_count  <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      sat_count  <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (sat_ev && (sat_count != 16'hffff))
        sat_count <= sat_count + 16'd1;
      if (drop && (drop_count != 16'hffff))
        drop_count <= drop_count + 16'd1;
      if (sat_ev || drop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_out_quantizer.sv
// Bench for fir_out_quantizer: directed plan steps plus random traffic,
// checked every cycle against a queue-based reference model.

module tb_fir_out_quantizer;

  localparam int SHIFT = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [23:0] data_in = '0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic [2:0]  level;
  logic [15:0] sat_count;
  logic [15:0] drop_count;
  logic        overflow;

  always #5 clk = ~clk;

  fir_out_quantizer #(.SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .data_in    (data_in),
    .clear      (clear),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .sat_count  (sat_count),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  int tests = 0;
  int fails = 0;

  int mq[$];
  bit m_qv;
  bit m_qs;
  int m_qd;
  int m_sat;
  int m_drop;
  bit m_ovf;
  int m_out;
  int got[$];

  function automatic real rq(input logic [23:0] x);
    int xi;
    xi = int'($signed(x));
    return $floor((real'(xi) + real'(2 ** (SHIFT - 1)))
                  / real'(2 ** SHIFT));
  endfunction

  function automatic bit qsat(input logic [23:0] x);
    real v;
    v = rq(x);
    return (v > 32767.0) || (v < -32768.0);
  endfunction

  function automatic int qval(input logic [23:0] x);
    real v;
    v = rq(x);
    if (v > 32767.0) return 32767;
    if (v < -32768.0) return -32768;
    return int'(v);
  endfunction

  task automatic check(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_qv = 0; m_qs = 0; m_qd = 0;
    m_sat = 0; m_drop = 0; m_ovf = 0; m_out = 0;
  endtask

  task automatic check_all();
    check("out_valid", out_valid, mq.size() > 0);
    check("level", level, mq.size());
    check("out_data", $signed(out_data), m_out);
    check("sat_count", sat_count, m_sat);
    check("drop_count", drop_count, m_drop);
    check("overflow", overflow, m_ovf);
  endtask

  task automatic drive(input bit e, input logic [23:0] d,
                       input bit rdy, input bit c);
    en = e; data_in = d; out_ready = rdy; clear = c;
  endtask

  task automatic tick();
    int sz;
    bit pop;
    bit sev;
    bit dev;
    if (out_valid && out_ready)
      got.push_back(int'($signed(out_data)));
    @(posedge clk);
    sz  = mq.size();
    pop = (sz > 0) && out_ready;
    if (pop) void'(mq.pop_front());
    dev = 0;
    if (m_qv) begin
      if (sz < DEPTH || pop) mq.push_back(m_qd);
      else dev = 1;
    end
    sev = m_qv && m_qs;
    if (clear) begin
      m_sat = 0; m_drop = 0; m_ovf = 0;
    end else begin
      if (sev && m_sat < 65535) m_sat++;
      if (dev && m_drop < 65535) m_drop++;
      if (sev || dev) m_ovf = 1;
    end
    m_qv = en;
    if (en) begin
      m_qd = qval(data_in);
      m_qs = qsat(data_in);
    end
    if (mq.size() > 0) m_out = mq[0];
    #1;
    check_all();
  endtask

  initial begin
    logic [23:0] d;
    model_reset();
    drive(0, '0, 0, 0);
    #12;
    check_all();
    check("rst_out_data", $signed(out_data), 0);
    reset = 1'b1;

    // rounding
    got.delete();
    drive(1, 24'h000180, 1, 0); tick();
    check("rnd_lat", out_valid, 0);
    drive(1, 24'hFFFE80, 1, 0); tick();
    check("rnd_first_v", out_valid, 1);
    check("rnd_first_d", $signed(out_data), 2);
    drive(1, 24'h00007F, 1, 0); tick();
    drive(1, 24'h000080, 1, 0); tick();
    drive(0, '0, 1, 0);
    repeat (3) tick();
    check("rnd_n", got.size(), 4);
    if (got.size() == 4) begin
      check("rnd_0", got[0], 2);
      check("rnd_1", got[1], -1);
      check("rnd_2", got[2], 0);
      check("rnd_3", got[3], 1);
    end
    check("rnd_sat", sat_count, 0);

    // saturation
    got.delete();
    drive(1, 24'h7FFFFF, 1, 0); tick();
    drive(1, 24'h7FFF80, 1, 0); tick();
    drive(1, 24'h800000, 1, 0); tick();
    drive(0, '0, 1, 0);
    repeat (4) tick();
    check("sat_n", got.size(), 3);
    if (got.size() == 3) begin
      check("sat_0", got[0], 32767);
      check("sat_1", got[1], 32767);
      check("sat_2", got[2], -32768);
    end
    check("sat_cnt", sat_count, 2);
    check("sat_ovf", overflow, 1);

    // full FIFO drop
    got.delete();
    for (int i = 1; i <= 6; i++) begin
      drive(1, 24'(i << 8), 0, 0);
      tick();
    end
    drive(0, '0, 0, 0); tick();
    check("drop_level", level, 4);
    check("drop_cnt", drop_count, 2);
    drive(0, '0, 1, 0);
    repeat (5) tick();
    check("drop_n", got.size(), 4);
    for (int i = 0; i < got.size(); i++)
      check("drop_seq", got[i], i + 1);

    // simultaneous push/pop at full
    got.delete();
    for (int i = 0; i < 5; i++) begin
      drive(1, 24'((20 + i) << 8), 0, 0);
      tick();
    end
    check("pp_fill", level, 4);
    for (int i = 0; i < 10; i++) begin
      drive(1, 24'((25 + i) << 8), 1, 0);
      tick();
      check("pp_level", level, 4);
      check("pp_drop", drop_count, 2);
    end
    drive(0, '0, 1, 0);
    repeat (6) tick();
    check("pp_n", got.size(), 15);
    for (int i = 0; i < got.size(); i++)
      check("pp_seq", got[i], 20 + i);

    // clear wins over a coincident saturation event
    drive(1, 24'h7FFFFF, 1, 0); tick();
    drive(0, '0, 1, 1); tick();
    check("clr_sat", sat_count, 0);
    check("clr_ovf", overflow, 0);
    check("clr_drop", drop_count, 0);
    drive(0, '0, 1, 0);
    repeat (3) tick();

    // random traffic
    repeat (400) begin
      case ($urandom_range(0, 3))
        0: d = 24'($urandom);
        1: d = 24'h7FFF00 + 24'($urandom_range(0, 255));
        2: d = 24'h800000 + 24'($urandom_range(0, 255));
        default: d = 24'($urandom_range(0, 1023)) - 24'd512;
      endcase
      drive($urandom_range(0, 3) != 0, d,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 40) == 0);
      tick();
    end

    // asynchronous reset mid-stream
    drive(0, '0, 1, 0);
    repeat (6) tick();
    drive(1, 24'h000500, 0, 0); tick();
    drive(1, 24'h000600, 0, 0); tick();
    drive(1, 24'h7FFFFF, 0, 0); tick();
    drive(0, '0, 0, 0); tick();
    check("ar_level3", level, 3);
    #3;
    reset = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_level", level, 0);
    check("ar_sat", sat_count, 0);
    check("ar_drop", drop_count, 0);
    check("ar_ovf", overflow, 0);
    check("ar_data", $signed(out_data), 0);
    model_reset();
    #2;
    reset = 1'b1;
    drive(1, 24'h000900, 1, 0); tick();
    check("ar_lat1", out_valid, 0);
    drive(0, '0, 1, 0); tick();
    check("ar_lat2_v", out_valid, 1);
    check("ar_lat2_d", $signed(out_data), 9);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
